// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: state encodings, default
// fetch timeout and retire-counter width.
package cpu_sequencer_pkg;

  localparam int unsigned DefaultTimeout = 255;
  localparam int unsigned RetiredWidth   = 16;
  localparam int unsigned StateWidth     = 3;

  // Codes 011, 101, 110 and 111 are illegal and trap to StFetch.
  typedef enum logic [StateWidth-1:0] {
    StFetch = 3'b000,
    StExec1 = 3'b001,
    StExec2 = 3'b010,
    StHalt  = 3'b100
  } state_e;

endpackage

// File: rtl/fetch_timer.sv
// Fetch wait counter: counts cycles spent in FETCH without a memory ack and
// flags the cycle on which the TIMEOUT-th consecutive wait completes.
module fetch_timer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Expiry fires on the wait cycle that would bring the count to TIMEOUT.
  assign expired = count_en && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (count_en && !expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: FETCH / EXEC1 / EXEC2 / HALT control FSM with fetch
// timeout, prefetch bypass, halt at instruction boundaries and retire counter.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_ack,
  input  logic                    extra,
  input  logic                    p,
  input  logic                    halt_req,
  input  logic                    run,
  output logic                    fetch,
  output logic                    exec1,
  output logic                    exec2,
  output logic                    mem_req,
  output logic                    ir_load,
  output logic                    pc_inc,
  output logic                    instr_done,
  output logic                    halted,
  output logic                    mem_err,
  output logic                    state_err,
  output logic [StateWidth-1:0]   state,
  output logic [RetiredWidth-1:0] retired
);

  state_e                  state_q, state_d;
  logic [RetiredWidth-1:0] retired_q, retired_d;
  logic                    mem_err_q, mem_err_d;
  logic                    state_err_q, state_err_d;
  logic                    timer_count_en;
  logic                    timer_expired;
  logic                    complete;

  assign timer_count_en = (state_q == StFetch) && !mem_ack;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch_timer (
    .clk      (clk),
    .rst      (rst),
    .count_en (timer_count_en),
    .expired  (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    retired_d   = retired_q;
    mem_err_d   = mem_err_q;
    state_err_d = state_err_q;
    fetch       = 1'b0;
    exec1       = 1'b0;
    exec2       = 1'b0;
    mem_req     = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    instr_done  = 1'b0;
    halted      = 1'b0;
    complete    = 1'b0;

    case (state_q)
      StFetch: begin
        fetch   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = StExec1;
        end else if (timer_expired) begin
          mem_err_d = 1'b1;
          state_d   = StHalt;
        end
      end
      StExec1: begin
        exec1 = 1'b1;
        if (extra) begin
          state_d = StExec2;
        end else begin
          complete = 1'b1;
        end
      end
      StExec2: begin
        exec2    = 1'b1;
        complete = 1'b1;
      end
      StHalt: begin
        halted = 1'b1;
        if (run) begin
          state_d = StFetch;
        end
      end
      default: begin
        state_err_d = 1'b1;
        state_d     = StFetch;
      end
    endcase

    // Instruction boundary: a pending halt wins over a valid prefetch.
    if (complete) begin
      instr_done = 1'b1;
      retired_d  = retired_q + RetiredWidth'(1);
      if (halt_req) begin
        state_d = StHalt;
      end else if (p) begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        state_d = StExec1;
      end else begin
        state_d = StFetch;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFetch;
      retired_q   <= '0;
      mem_err_q   <= 1'b0;
      state_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      retired_q   <= retired_d;
      mem_err_q   <= mem_err_d;
      state_err_q <= state_err_d;
    end
  end

  assign state     = state_q;
  assign retired   = retired_q;
  assign mem_err   = mem_err_q;
  assign state_err = state_err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: vector table with scoreboard queue,
// plus hand sequences for timeout, async reset, counter wrap and illegal state.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_ack, extra, p, halt_req, run;
  logic        fetch, exec1, exec2, mem_req, ir_load, pc_inc, instr_done, halted;
  logic        mem_err, state_err;
  logic [2:0]  state;
  logic [15:0] retired;

  int n_cmp = 0;
  int n_err = 0;

  cpu_sequencer #(
    .TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_ack    (mem_ack),
    .extra      (extra),
    .p          (p),
    .halt_req   (halt_req),
    .run        (run),
    .fetch      (fetch),
    .exec1      (exec1),
    .exec2      (exec2),
    .mem_req    (mem_req),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .instr_done (instr_done),
    .halted     (halted),
    .mem_err    (mem_err),
    .state_err  (state_err),
    .state      (state),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack, ext, pf, hreq, rn;
    logic [2:0]  st;
    logic        mr, il, pi, dn, hl;
    logic [15:0] ret;
  } vec_t;

  vec_t vecs[19];
  vec_t sb_q[$];

  function automatic vec_t mk(input logic ack, ext, pf, hreq, rn, input logic [2:0] st,
                              input logic mr, il, pi, dn, hl, input logic [15:0] ret);
    vec_t v;
    v.ack = ack; v.ext = ext; v.pf = pf; v.hreq = hreq; v.rn = rn;
    v.st = st; v.mr = mr; v.il = il; v.pi = pi; v.dn = dn; v.hl = hl; v.ret = ret;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ack, ext, pf, hreq, rn);
    mem_ack = ack; extra = ext; p = pf; halt_req = hreq; run = rn;
  endtask

  initial begin
    vec_t e;
    // ack ext p hreq run | state mr il pi done halted retired(before edge)
    vecs[0]  = mk(0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 16'd0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 16'd0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 3'b000, 1, 1, 1, 0, 0, 16'd0);
    vecs[3]  = mk(0, 1, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 16'd0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 1, 0, 16'd0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 3'b000, 1, 1, 1, 0, 0, 16'd1);
    vecs[6]  = mk(0, 0, 1, 0, 0, 3'b001, 0, 1, 1, 1, 0, 16'd1);
    vecs[7]  = mk(0, 0, 1, 0, 0, 3'b001, 0, 1, 1, 1, 0, 16'd2);
    vecs[8]  = mk(0, 0, 1, 0, 0, 3'b001, 0, 1, 1, 1, 0, 16'd3);
    vecs[9]  = mk(0, 0, 1, 0, 0, 3'b001, 0, 1, 1, 1, 0, 16'd4);
    vecs[10] = mk(0, 0, 1, 1, 0, 3'b001, 0, 0, 0, 1, 0, 16'd5);
    vecs[11] = mk(1, 0, 0, 1, 0, 3'b100, 0, 0, 0, 0, 1, 16'd6);
    vecs[12] = mk(0, 0, 0, 0, 1, 3'b100, 0, 0, 0, 0, 1, 16'd6);
    vecs[13] = mk(0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 16'd6);
    vecs[14] = mk(0, 0, 0, 1, 0, 3'b000, 1, 0, 0, 0, 0, 16'd6);
    vecs[15] = mk(1, 0, 0, 1, 0, 3'b000, 1, 1, 1, 0, 0, 16'd6);
    vecs[16] = mk(0, 1, 0, 1, 0, 3'b001, 0, 0, 0, 0, 0, 16'd6);
    vecs[17] = mk(0, 0, 1, 1, 0, 3'b010, 0, 0, 0, 1, 0, 16'd6);
    vecs[18] = mk(0, 0, 0, 0, 0, 3'b100, 0, 0, 0, 0, 1, 16'd7);

    // Async reset before any clock edge.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    #2;
    chk("reset state", 16'(state), 16'd0);
    chk("reset mem_req", 16'(mem_req), 16'd1);
    chk("reset retired", retired, 16'd0);
    chk("reset mem_err", 16'(mem_err), 16'd0);
    chk("reset state_err", 16'(state_err), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].ack, vecs[i].ext, vecs[i].pf, vecs[i].hreq, vecs[i].rn);
      sb_q.push_back(vecs[i]);
      #1;
      e = sb_q.pop_front();
      chk($sformatf("v%0d state", i), 16'(state), 16'(e.st));
      chk($sformatf("v%0d fetch", i), 16'(fetch), 16'(e.st == 3'b000));
      chk($sformatf("v%0d exec1", i), 16'(exec1), 16'(e.st == 3'b001));
      chk($sformatf("v%0d exec2", i), 16'(exec2), 16'(e.st == 3'b010));
      chk($sformatf("v%0d mem_req", i), 16'(mem_req), 16'(e.mr));
      chk($sformatf("v%0d ir_load", i), 16'(ir_load), 16'(e.il));
      chk($sformatf("v%0d pc_inc", i), 16'(pc_inc), 16'(e.pi));
      chk($sformatf("v%0d instr_done", i), 16'(instr_done), 16'(e.dn));
      chk($sformatf("v%0d halted", i), 16'(halted), 16'(e.hl));
      chk($sformatf("v%0d retired", i), retired, e.ret);
      chk($sformatf("v%0d mem_err", i), 16'(mem_err), 16'd0);
      @(negedge clk);
    end

    // Fetch timeout: four unacknowledged wait cycles end in HALT with MEM_ERR.
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("to wait%0d state", k), 16'(state), 16'd0);
      chk($sformatf("to wait%0d mem_err", k), 16'(mem_err), 16'd0);
      @(negedge clk);
    end
    chk("to state", 16'(state), 16'd4);
    chk("to mem_err", 16'(mem_err), 16'd1);
    chk("to halted", 16'(halted), 16'd1);
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("to run state", 16'(state), 16'd0);
    chk("to run mem_err", 16'(mem_err), 16'd1);
    drive(1, 1, 0, 0, 0);
    @(negedge clk);
    chk("to exec1 mem_err", 16'(mem_err), 16'd1);
    @(negedge clk);
    chk("pre-rst exec2", 16'(state), 16'd2);

    // Async reset in EXEC2 abandons the instruction.
    #2;
    rst = 1'b1;
    #1;
    chk("rst exec2 state", 16'(state), 16'd0);
    chk("rst exec2 instr_done", 16'(instr_done), 16'd0);
    chk("rst exec2 mem_req", 16'(mem_req), 16'd1);
    chk("rst exec2 retired", retired, 16'd0);
    chk("rst exec2 mem_err", 16'(mem_err), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Retire counter wrap via back-to-back prefetched instructions.
    drive(1, 0, 1, 0, 0);
    @(posedge clk);
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap ffff", retired, 16'hffff);
    chk("wrap state", 16'(state), 16'd1);
    @(posedge clk);
    #1;
    chk("wrap 0000", retired, 16'h0000);

    // Illegal state trap.
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    force dut.state_q = state_e'(3'b111);
    #1;
    chk("ill state", 16'(state), 16'd7);
    chk("ill strobes", 16'({fetch, exec1, exec2, mem_req, ir_load, pc_inc, instr_done, halted}),
        16'd0);
    chk("ill state_err pre", 16'(state_err), 16'd0);
    release dut.state_q;
    @(posedge clk);
    #1;
    chk("ill state_err", 16'(state_err), 16'd1);
    chk("ill to fetch", 16'(state), 16'd0);
    @(negedge clk);
    chk("ill sticky", 16'(state_err), 16'd1);
    chk("ill fetch mem_req", 16'(mem_req), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum number of fetch wait cycles before a memory error.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 RESET  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 MEM_ACK  input  1  SHALL indicate that instruction memory returns data this cycle.
REQ-005 EXTRA  input  1  SHALL indicate that the current instruction needs a second execute cycle; it is sampled in EXEC1.
REQ-006 P  input  1  SHALL indicate that a prefetched instruction is valid; it is sampled at instruction completion.
REQ-007 HALT_REQ  input  1  SHALL request a halt at the next instruction boundary.
REQ-008 RUN  input  1  SHALL release the sequencer from HALT.
REQ-009 FETCH, EXEC1, EXEC2  output  1 each  SHALL be one-hot decodes of the registered state.
REQ-010 MEM_REQ  output  1  SHALL request an instruction fetch.
REQ-011 IR_LOAD  output  1  SHALL load the instruction register.
REQ-012 PC_INC  output  1  SHALL increment the PC.
REQ-013 INSTR_DONE  output  1  SHALL pulse for one cycle when an instruction retires.
REQ-014 HALTED  output  1  SHALL be high in HALT.
REQ-015 MEM_ERR  output  1  SHALL be a sticky fetch-timeout flag.
REQ-016 STATE_ERR  output  1  SHALL be a sticky illegal-state flag.
REQ-017 STATE  output  3  SHALL expose the registered state.
REQ-018 RETIRED  output  16  SHALL count retired instructions.

Function
REQ-019 State encodings SHALL be: FETCH=000, EXEC1=001, EXEC2=010, HALT=100; the codes 011, 101, 110 and 111 are illegal.
REQ-020 In FETCH, MEM_REQ SHALL be 1; with MEM_ACK=1, IR_LOAD=PC_INC=1 (combinational) and the next state is EXEC1; with MEM_ACK=0 the state holds and the wait counter increments.
REQ-021 When the wait counter reaches TIMEOUT with MEM_ACK still 0, the sequencer SHALL set MEM_ERR and enter HALT; the counter clears on every exit from FETCH.
REQ-022 In EXEC1 with EXTRA=1, the next state SHALL be EXEC2, with no retire.
REQ-023 In EXEC1 with EXTRA=0, and in EXEC2, the instruction SHALL complete: INSTR_DONE=1 and RETIRED increments, wrapping from 0xFFFF to 0x0000.
REQ-024 At completion, HALT_REQ=1 SHALL select HALT, overriding P; else P=1 SHALL select EXEC1 with IR_LOAD=PC_INC=1 (prefetch consumed); else the next state is FETCH.
REQ-025 In HALT, MEM_REQ, IR_LOAD and PC_INC SHALL be 0; RUN=1 SHALL select FETCH next; HALT_REQ is ignored in HALT.
REQ-026 An illegal state SHALL set STATE_ERR and move to FETCH on the next edge; all strobes are 0 during that cycle.
REQ-027 FETCH, EXEC1, EXEC2, MEM_REQ, IR_LOAD, PC_INC, INSTR_DONE and HALTED SHALL be decoded from the state register and current inputs only, with zero added latency.
REQ-028 HALT_REQ asserted mid-instruction, in FETCH or in EXEC1 with EXTRA=1, SHALL take effect only at completion.

Reset
REQ-029 RESET=1 SHALL immediately force state=FETCH, wait counter=0, RETIRED=0, MEM_ERR=0 and STATE_ERR=0, regardless of CLK.
REQ-030 After RESET falls, the first edge SHALL evaluate FETCH normally; MEM_REQ=1 during reset.
REQ-031 Reset asserted mid-fetch or in EXEC2 SHALL abandon the instruction without INSTR_DONE.

Structure
REQ-032 A shared package SHALL hold the state encodings, the default TIMEOUT and the RETIRED width.
REQ-033 The sequencer SHALL instantiate one sub-module, fetch_timer, containing the wait counter and timeout compare.

Verification
REQ-034 The bench SHALL cover: reset, then MEM_ACK=1 at cycle 3 -> FETCH for 3 cycles, IR_LOAD on cycle 3, EXEC1 on cycle 4.
REQ-035 The bench SHALL cover: EXTRA=1 in EXEC1, then P=0 -> EXEC1, EXEC2, FETCH, with one INSTR_DONE and RETIRED=1.
REQ-036 The bench SHALL cover: P=1 at each completion for 4 instructions with EXTRA=0 -> EXEC1 held for 4 cycles, 4 IR_LOAD pulses, RETIRED=4.
REQ-037 The bench SHALL cover: HALT_REQ=1 and P=1 at completion -> HALT, HALTED=1; RUN=1 -> FETCH next cycle.
REQ-038 The bench SHALL cover: TIMEOUT=4 with MEM_ACK held 0 -> MEM_ERR=1 after 4 wait cycles, state=HALT; MEM_ERR stays 1 after RUN until RESET.
REQ-039 The bench SHALL cover: RETIRED preloaded to 0xFFFF via 65535 retires, then one more -> 0x0000; forcing state=111 -> STATE_ERR=1, then FETCH.
